// File: rtl/am2940_param_if.sv
// Bus bundle for the am2940_param DMA address generator: instruction, data,
// cascade carries and the transfer-complete flag.
interface am2940_param_if #(
  parameter int unsigned WIDTH = 8
);
  logic [2:0]       instr;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] addr_out;
  logic             acineg;
  logic             aconeg;
  logic             wcineg;
  logic             wconeg;
  logic             done;

  modport master (
    output instr, data_in, acineg, wcineg,
    input  data_out, addr_out, aconeg, wconeg, done
  );

  modport slave (
    input  instr, data_in, acineg, wcineg,
    output data_out, addr_out, aconeg, wconeg, done
  );
endinterface

// File: rtl/am2940_param.sv
// Am2940-style DMA address generator: control, address and word registers
// and counters, with four transfer modes, autoreload and cascade carries.
module am2940_param #(
  parameter int unsigned WIDTH = 8
) (
  input logic           clk,
  input logic           rstneg,
  am2940_param_if.slave bus
);

  typedef enum logic [2:0] {
    WR_CR   = 3'b000,
    RD_CR   = 3'b001,
    RD_WC   = 3'b010,
    RD_AC   = 3'b011,
    REINIT  = 3'b100,
    LD_ADDR = 3'b101,
    LD_WORD = 3'b110,
    ENABLE  = 3'b111
  } instr_e;

  logic [3:0]       cr_q, cr_d;
  logic [WIDTH-1:0] ar_q, ar_d;
  logic [WIDTH-1:0] ac_q, ac_d;
  logic [WIDTH-1:0] wr_q, wr_d;
  logic [WIDTH-1:0] wc_q, wc_d;

  instr_e     op;
  logic [1:0] mode;
  logic       dir;
  logic       autoreload;
  logic       wc_up;
  logic       done_w;
  logic       ac_term;
  logic       wc_term;

  assign op         = instr_e'(bus.instr);
  assign mode       = cr_q[1:0];
  assign dir        = cr_q[2];
  assign autoreload = cr_q[3];
  // Modes 1 and 2 count words upward from zero; modes 0 and 3 count down.
  assign wc_up      = mode[0] ^ mode[1];

  always_comb begin
    done_w = 1'b0;
    case (mode)
      2'd0:    done_w = (wc_q == WIDTH'(1));
      2'd1:    done_w = (wc_q == wr_q);
      2'd2:    done_w = (ac_q == wr_q);
      default: done_w = 1'b0;
    endcase
  end

  assign ac_term = dir   ? (ac_q == '0) : (ac_q == '1);
  assign wc_term = wc_up ? (wc_q == '1) : (wc_q == '0);

  always_comb begin
    cr_d = cr_q;
    ar_d = ar_q;
    ac_d = ac_q;
    wr_d = wr_q;
    wc_d = wc_q;
    case (op)
      WR_CR: cr_d = bus.data_in[3:0];
      REINIT: begin
        ac_d = ar_q;
        wc_d = wc_up ? '0 : wr_q;
      end
      LD_ADDR: begin
        ar_d = bus.data_in;
        ac_d = bus.data_in;
      end
      LD_WORD: begin
        wr_d = bus.data_in;
        wc_d = wc_up ? '0 : bus.data_in;
      end
      ENABLE: begin
        // A completed transfer either reloads (autoreload) or freezes.
        if (done_w) begin
          if (autoreload) begin
            ac_d = ar_q;
            wc_d = wc_up ? '0 : wr_q;
          end
        end else begin
          if (!bus.acineg) ac_d = dir   ? ac_q - WIDTH'(1) : ac_q + WIDTH'(1);
          if (!bus.wcineg) wc_d = wc_up ? wc_q + WIDTH'(1) : wc_q - WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstneg) begin
    if (!rstneg) begin
      cr_q <= '0;
      ar_q <= '0;
      ac_q <= '0;
      wr_q <= '0;
      wc_q <= '0;
    end else begin
      cr_q <= cr_d;
      ar_q <= ar_d;
      ac_q <= ac_d;
      wr_q <= wr_d;
      wc_q <= wc_d;
    end
  end

  always_comb begin
    bus.data_out = '0;
    case (op)
      RD_CR:   bus.data_out = WIDTH'(cr_q);
      RD_WC:   bus.data_out = wc_q;
      RD_AC:   bus.data_out = ac_q;
      default: bus.data_out = '0;
    endcase
  end

  assign bus.addr_out = ac_q;
  assign bus.done     = done_w;
  assign bus.aconeg   = !((op == ENABLE) && !bus.acineg && !done_w && ac_term);
  assign bus.wconeg   = !((op == ENABLE) && !bus.wcineg && !done_w && wc_term);

endmodule

// File: tb/tb_am2940_param.sv
// Directed-vector bench for am2940_param: 8-bit instance for all modes and
// a 16-bit instance for the wide decrement wrap.
module tb_am2940_param;

  logic clk;
  logic rstneg = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  am2940_param_if #(.WIDTH(8))  bus8 ();
  am2940_param_if #(.WIDTH(16)) bus16 ();

  am2940_param #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rstneg(rstneg),
    .bus   (bus8)
  );

  am2940_param #(.WIDTH(16)) u_dut16 (
    .clk   (clk),
    .rstneg(rstneg),
    .bus   (bus16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] i, input logic [7:0] d,
                       input logic aci = 1'b1, input logic wci = 1'b1);
    bus8.instr   = i;
    bus8.data_in = d;
    bus8.acineg  = aci;
    bus8.wcineg  = wci;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all;
    drive(3'b001, 8'h00);
    rstneg = 1'b0;
    tick;
    rstneg = 1'b1;
  endtask

  initial begin
    bus8.instr    = 3'b001;
    bus8.data_in  = '0;
    bus8.acineg   = 1'b1;
    bus8.wcineg   = 1'b1;
    bus16.instr   = 3'b001;
    bus16.data_in = '0;
    bus16.acineg  = 1'b1;
    bus16.wcineg  = 1'b1;
    #1 rstneg = 1'b0;
    tick;
    check("rst_addr",   bus8.addr_out, 32'h0);
    check("rst_data",   bus8.data_out, 32'h0);
    check("rst_done",   bus8.done,     32'h0);
    check("rst_aconeg", bus8.aconeg,   32'h1);
    check("rst_wconeg", bus8.wconeg,   32'h1);
    rstneg = 1'b1;

    // Mode 1 word register vs. counter
    drive(3'b000, 8'h01); tick;
    drive(3'b110, 8'h66); tick;
    drive(3'b010, 8'h00);
    check("m1_wc_zero", bus8.data_out, 32'h00);
    check("m1_done",    bus8.done,     32'h0);
    drive(3'b001, 8'h00);
    check("rd_cr",      bus8.data_out, 32'h01);
    drive(3'b000, 8'h00); tick;
    drive(3'b100, 8'h00);
    check("nonread_data0", bus8.data_out, 32'h00);
    tick;
    drive(3'b010, 8'h00);
    check("m0_wc_reinit", bus8.data_out, 32'h66);

    // Mode 0 count to done, then freeze
    reset_all;
    drive(3'b101, 8'h10); tick;
    check("ld_addr", bus8.addr_out, 32'h10);
    drive(3'b110, 8'h03); tick;
    drive(3'b111, 8'h00, 1'b0, 1'b0); tick; tick;
    check("m0_ac", bus8.addr_out, 32'h12);
    drive(3'b010, 8'h00);
    check("m0_wc",   bus8.data_out, 32'h01);
    check("m0_done", bus8.done,     32'h1);
    drive(3'b111, 8'h00, 1'b0, 1'b0);
    check("m0_stop_aconeg", bus8.aconeg, 32'h1);
    tick;
    check("m0_hold_ac", bus8.addr_out, 32'h12);
    drive(3'b010, 8'h00);
    check("m0_hold_wc", bus8.data_out, 32'h01);

    // Enables gate counters independently
    reset_all;
    drive(3'b101, 8'h20); tick;
    drive(3'b110, 8'h09); tick;
    drive(3'b111, 8'h00, 1'b1, 1'b0); tick;
    check("acineg_hold", bus8.addr_out, 32'h20);
    drive(3'b011, 8'h00);
    check("rd_ac", bus8.data_out, 32'h20);
    drive(3'b010, 8'h00);
    check("wc_dec_only", bus8.data_out, 32'h08);
    drive(3'b111, 8'h00, 1'b0, 1'b1); tick;
    check("ac_inc_only", bus8.addr_out, 32'h21);
    drive(3'b010, 8'h00);
    check("wcineg_hold", bus8.data_out, 32'h08);

    // Increment wrap carry
    reset_all;
    drive(3'b101, 8'hFF); tick;
    drive(3'b111, 8'h00, 1'b0, 1'b1);
    check("inc_aconeg", bus8.aconeg, 32'h0);
    check("inc_wconeg_off", bus8.wconeg, 32'h1);
    tick;
    check("inc_wrap", bus8.addr_out, 32'h00);

    // Decrement wrap with both carries
    reset_all;
    drive(3'b000, 8'h04); tick;
    drive(3'b101, 8'h00); tick;
    drive(3'b111, 8'h00, 1'b0, 1'b0);
    check("dec_aconeg", bus8.aconeg, 32'h0);
    check("dec_wconeg", bus8.wconeg, 32'h0);
    tick;
    check("dec_wrap", bus8.addr_out, 32'hFF);
    check("dec_aconeg_after", bus8.aconeg, 32'h1);
    drive(3'b010, 8'h00);
    check("dec_wc_wrap", bus8.data_out, 32'hFF);

    // Autoreload
    reset_all;
    drive(3'b000, 8'h08); tick;
    drive(3'b101, 8'h40); tick;
    drive(3'b110, 8'h02); tick;
    drive(3'b111, 8'h00, 1'b0, 1'b0); tick;
    check("ar_ac1",   bus8.addr_out, 32'h41);
    check("ar_done1", bus8.done,     32'h1);
    tick;
    check("ar_reload_ac", bus8.addr_out, 32'h40);
    check("ar_done2",     bus8.done,     32'h0);
    drive(3'b010, 8'h00);
    check("ar_reload_wc", bus8.data_out, 32'h02);
    drive(3'b111, 8'h00, 1'b0, 1'b0); tick;
    check("ar_ac3", bus8.addr_out, 32'h41);

    // Mode 2 address compare
    reset_all;
    drive(3'b000, 8'h02); tick;
    drive(3'b110, 8'h05); tick;
    drive(3'b101, 8'h03); tick;
    drive(3'b111, 8'h00, 1'b0, 1'b0); tick;
    check("m2_ac4",   bus8.addr_out, 32'h04);
    check("m2_done0", bus8.done,     32'h0);
    tick;
    check("m2_ac5",   bus8.addr_out, 32'h05);
    check("m2_done1", bus8.done,     32'h1);
    tick;
    check("m2_hold", bus8.addr_out, 32'h05);
    drive(3'b010, 8'h00);
    check("m2_wc", bus8.data_out, 32'h02);

    // Mode 3 never completes
    drive(3'b000, 8'h03); tick;
    check("m3_done", bus8.done, 32'h0);

    // Asynchronous reset mid-enable
    reset_all;
    drive(3'b101, 8'h36); tick;
    drive(3'b111, 8'h00, 1'b0, 1'b0); tick;
    check("pre_rst_ac", bus8.addr_out, 32'h37);
    #2 rstneg = 1'b0;
    #1;
    check("async_rst_ac",   bus8.addr_out, 32'h00);
    check("async_rst_done", bus8.done,     32'h0);
    rstneg = 1'b1;
    tick;
    check("post_rst_enable", bus8.addr_out, 32'h01);

    // 16-bit decrement wrap
    reset_all;
    bus16.instr = 3'b000; bus16.data_in = 16'h0004; tick;
    bus16.instr = 3'b101; bus16.data_in = 16'h0000; tick;
    bus16.instr = 3'b111; bus16.acineg = 1'b0; bus16.wcineg = 1'b0;
    #1;
    check("w16_aconeg", bus16.aconeg, 32'h0);
    tick;
    check("w16_wrap", bus16.addr_out, 32'hFFFF);
    bus16.instr = 3'b001; bus16.acineg = 1'b1; bus16.wcineg = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/am2940_param.md
AM2940_PARAM -- requirements
Module: am2940_param

Interface
REQ-001 Parameter: WIDTH, default 8, bit width of data, address and word paths (minimum 4).
REQ-002 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-003 Port: rstneg  input  1  reset, asynchronous, active-low.
REQ-004 Port: instr  input  3  instruction code, sampled every rising clk edge.
REQ-005 Port: data_in  input  WIDTH  load data.
REQ-006 Port: data_out  output  WIDTH  read data; 0 when instr is not a read.
REQ-007 Port: addr_out  output  WIDTH  address counter (AC) value, continuous.
REQ-008 Port: acineg  input  1  address count enable, active-low (cascade carry-in).
REQ-009 Port: aconeg  output  1  address carry-out, active-low.
REQ-010 Port: wcineg  input  1  word count enable, active-low (cascade carry-in).
REQ-011 Port: wconeg  output  1  word carry-out, active-low.
REQ-012 Port: done  output  1  transfer-complete flag, active-high, combinational from state.

Function
REQ-013 State shall be: CR[3:0] (mode=CR[1:0], dir=CR[2] 0 inc/1 dec, autoreload=CR[3]), AR, AC, WR, WC, each WIDTH bits except CR.
REQ-014 000 WRITE CR: CR <= data_in[3:0]; counters unchanged.
REQ-015 001/010/011 READ CR/WC/AC: data_out = CR zero-extended / WC / AC, combinational from current instr; no state change.
REQ-016 100 REINIT: AC <= AR; WC <= 0 in modes 1,2, else WC <= WR.
REQ-017 101 LOAD ADDRESS: AR <= data_in, AC <= data_in.
REQ-018 110 LOAD WORD: WR <= data_in; WC <= 0 in modes 1,2, else WC <= data_in.
REQ-019 111 ENABLE: if acineg=0, AC <= AC+1 (dir=0) or AC-1 (dir=1), modulo 2^WIDTH.
REQ-020 111 ENABLE: if wcineg=0, WC <= WC-1 in modes 0,3; WC <= WC+1 in modes 1,2; modulo 2^WIDTH.
REQ-021 done: mode 0 WC==1; mode 1 WC==WR; mode 2 AC==WR; mode 3 always 0.
REQ-022 ENABLE with done=1 and autoreload=0: AC and WC hold (transfer stops).
REQ-023 ENABLE with done=1 and autoreload=1: perform REINIT (REQ-016) instead of counting, same cycle.
REQ-024 aconeg=0 iff instr=111, acineg=0, done/stop not active, and AC=all-ones (dir=0) or all-zeros (dir=1).
REQ-025 wconeg=0 iff instr=111, wcineg=0, done/stop not active, and WC at terminal value for its count direction (all-zeros dec, all-ones inc).
REQ-026 Non-ENABLE instructions: AC and WC change only as listed; counters never count.
REQ-027 Mode change via WRITE CR does not alter AR/AC/WR/WC; new mode affects done and next REINIT/LOAD WORD only.
REQ-028 Single-cycle latency: loads and count steps visible on addr_out/data_out the cycle after the edge.

Reset
REQ-029 rstneg=0 shall immediately clear CR, AR, AC, WR, WC to 0, independent of clk.
REQ-030 During and after reset: addr_out=0, data_out=0 unless read instr present (then reads 0), done=0 (mode 0, WC=0), aconeg=wconeg=1 unless REQ-024/025 hold.
REQ-031 Reset asserted mid-ENABLE shall abort counting; first edge after release executes instr normally.

Verification
REQ-032 Mode 1 word register: WRITE CR 0x1, LOAD WORD 0x66, READ WC -> 0x00; WRITE CR 0x0, REINIT, READ WC -> 0x66.
REQ-033 Mode 0 count: CR=0, LOAD ADDRESS 0x10, LOAD WORD 0x03, ENABLE (acineg=wcineg=0) 2 cycles -> AC=0x12, WC=0x01, done=1; 3rd ENABLE -> AC stays 0x12.
REQ-034 Decrement wrap: CR=0x4, LOAD ADDRESS 0x00, ENABLE 1 cycle -> aconeg=0 during cycle, AC=0xFF after.
REQ-035 Autoreload: CR=0x8, LOAD ADDRESS 0x40, LOAD WORD 0x02, ENABLE 3 cycles -> AC 0x41 (done=1), then AC=0x40, WC=0x02, done=0.
REQ-036 Mode 2 compare: CR=0x2, LOAD WORD 0x05, LOAD ADDRESS 0x03, ENABLE -> done=1 at AC=0x05, AC holds.
REQ-037 Async reset: AC=0x37 mid-ENABLE, rstneg=0 between edges -> addr_out=0 immediately; WIDTH=16 instance repeats REQ-034 with AC=0xFFFF.
